// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush scheduler: FSM states, hazard
// priority encoding and the priority-resolution helper.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    HZ_NONE = 2'd0,
    HZ_LU   = 2'd1,
    HZ_BR   = 2'd2,
    HZ_MW   = 2'd3
  } hz_prio_t;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         WCNT_W   = 8;

  // Memory wait freezes everything; a branch squashes Decode so it beats load-use.
  function automatic hz_prio_t hz_select(input logic mw, input logic br, input logic lu);
    hz_prio_t p;
    p = HZ_NONE;
    if (mw)      p = HZ_MW;
    else if (br) p = HZ_BR;
    else if (lu) p = HZ_LU;
    return p;
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter used for the optional stall/flush performance counters.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush scheduler for the five-stage RV32 pipeline (load-use, branch, memory wait).
// Performance counters are built only when PIPE_CTRL_PERF_EN is defined.
//
// state | meaning
// RUN   | no outstanding Memory-stage wait
// WAIT  | Memory-stage access pending; wait counter tracks elapsed cycles
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdE,
  input  logic             MemReadE,
  input  logic             PCSrcE,
  input  logic             MemAccessM,
  input  logic             DmemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             Control_mux,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam logic [WCNT_W-1:0] TIMEOUT_V = WCNT_W'(MEM_TIMEOUT);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WCNT_W-1:0] r_wait_cnt;
  logic [WCNT_W-1:0] w_wait_cnt_nxt;
  logic              r_mem_err;
  logic              w_mem_err_nxt;

  logic     w_lu;
  logic     w_br;
  logic     w_mw;
  logic     w_timeout;
  hz_prio_t w_prio;

  assign w_lu = MemReadE && (RdE != REG_ZERO) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign w_br = PCSrcE;

  // The timeout cycle itself releases the freeze; the access is abandoned.
  assign w_timeout = (r_state == WAIT) && !DmemReadyM && (r_wait_cnt == TIMEOUT_V);
  assign w_mw      = (r_state == RUN) ? (MemAccessM && !DmemReadyM)
                                      : (!DmemReadyM && !w_timeout);

  assign w_prio = hz_select(w_mw, w_br, w_lu);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_mem_err  <= w_mem_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_mem_err_nxt  = r_mem_err;
    case (r_state)
      RUN: begin
        if (MemAccessM && !DmemReadyM) begin
          w_state_nxt    = WAIT;
          w_wait_cnt_nxt = WCNT_W'(1);
        end
      end
      WAIT: begin
        if (DmemReadyM) begin
          w_state_nxt    = RUN;
          w_wait_cnt_nxt = '0;
        end else if (w_timeout) begin
          w_state_nxt    = RUN;
          w_wait_cnt_nxt = '0;
          w_mem_err_nxt  = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + WCNT_W'(1);
        end
      end
      default: begin
        w_state_nxt    = RUN;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    StallF      = 1'b0;
    StallD      = 1'b0;
    StallE      = 1'b0;
    StallM      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    FlushW      = 1'b0;
    Control_mux = 1'b0;
    if (reset) begin
      // Drain every register to a bubble while reset is held.
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else begin
      case (w_prio)
        HZ_MW: begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          StallM = 1'b1;
          FlushW = 1'b1;
        end
        HZ_BR: begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end
        HZ_LU: begin
          StallF      = 1'b1;
          StallD      = 1'b1;
          Control_mux = 1'b1;
        end
        default: begin
          StallF = 1'b0;
        end
      endcase
    end
  end

  assign MemErr = r_mem_err;

`ifdef PIPE_CTRL_PERF_EN
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (StallF),
    .o_cnt (StallCnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (FlushE && !reset),
    .o_cnt (FlushCnt)
  );
`else
  assign StallCnt = '0;
  assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed hazard scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_pipeline_ctrl;

  localparam int TO = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [4:0]    Rs1D, Rs2D, RdE;
  logic          MemReadE, PCSrcE, MemAccessM, DmemReadyM;
  logic          StallF, StallD, StallE, StallM;
  logic          FlushD, FlushE, FlushW, Control_mux, MemErr;
  logic [CW-1:0] StallCnt, FlushCnt;

  pipeline_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .Rs1D        (Rs1D),
    .Rs2D        (Rs2D),
    .RdE         (RdE),
    .MemReadE    (MemReadE),
    .PCSrcE      (PCSrcE),
    .MemAccessM  (MemAccessM),
    .DmemReadyM  (DmemReadyM),
    .StallF      (StallF),
    .StallD      (StallD),
    .StallE      (StallE),
    .StallM      (StallM),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .FlushW      (FlushW),
    .Control_mux (Control_mux),
    .MemErr      (MemErr),
    .StallCnt    (StallCnt),
    .FlushCnt    (FlushCnt)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model: age of the pending memory access (0 = none), sticky error, counters.
  int m_age  = 0;
  bit m_err  = 1'b0;
  int m_scnt = 0;
  int m_fcnt = 0;
  int m_max  = (1 << CW) - 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, check outputs mid-cycle, then advance the model.
  task automatic cycle(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rde, input logic mr, input logic pc,
                       input logic ma, input logic rdy);
    logic       lu, mw, tmo;
    logic [7:0] exp;
    reset = rst; Rs1D = rs1; Rs2D = rs2; RdE = rde;
    MemReadE = mr; PCSrcE = pc; MemAccessM = ma; DmemReadyM = rdy;
    #1;
    lu  = mr && (rde != 5'd0) && ((rde == rs1) || (rde == rs2));
    tmo = 1'b0;
    if (m_age == 0) begin
      mw = ma && !rdy;
    end else begin
      mw  = !rdy && (m_age < TO);
      tmo = !rdy && (m_age >= TO);
    end
    // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,Control_mux}
    if (rst)      exp = 8'b0000_1110;
    else if (mw)  exp = 8'b1111_0010;
    else if (pc)  exp = 8'b0000_1100;
    else if (lu)  exp = 8'b1100_0001;
    else          exp = 8'b0000_0000;
    check("ctrl", 32'({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, Control_mux}),
          32'(exp));
    check("MemErr", 32'(MemErr), 32'(m_err));
`ifdef PIPE_CTRL_PERF_EN
    check("StallCnt", 32'(StallCnt), 32'(m_scnt));
    check("FlushCnt", 32'(FlushCnt), 32'(m_fcnt));
`else
    check("StallCnt", 32'(StallCnt), 32'd0);
    check("FlushCnt", 32'(FlushCnt), 32'd0);
`endif
    @(posedge clk);
    if (rst) begin
      m_age = 0; m_err = 1'b0; m_scnt = 0; m_fcnt = 0;
    end else begin
      if (m_age == 0) begin
        if (mw) m_age = 1;
      end else if (rdy || tmo) begin
        m_age = 0;
      end else begin
        m_age++;
      end
      if (tmo) m_err = 1'b1;
      if (exp[7] && (m_scnt < m_max)) m_scnt++;
      if (exp[2] && (m_fcnt < m_max)) m_fcnt++;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    reset = 1'b1; Rs1D = '0; Rs2D = '0; RdE = '0;
    MemReadE = 1'b0; PCSrcE = 1'b0; MemAccessM = 1'b0; DmemReadyM = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // Reset state
    cycle(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);

    // Load-use on Rs2D, then the bubble in Execute
    cycle(1'b0, 5'd7, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 5'd7, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    // Load to x0 never stalls
    cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    // Load-use on Rs1D
    cycle(1'b0, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
    idle();

    // Branch coinciding with load-use
    cycle(1'b0, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    idle();

    // Single-cycle access: no stall
    cycle(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);

    // Memory wait, ready on the 4th cycle
    for (int i = 0; i < 3; i++) cycle(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    idle();

    // Memory wait with a coincident branch; flush shows up in the ready cycle
    for (int i = 0; i < 2; i++) cycle(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1);
    idle();

    // Timeout: ready never arrives, MemErr sets and stays
    for (int i = 0; i < TO + 1; i++) cycle(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) idle();

    // Counters: 20 stall cycles saturate a 4-bit counter
    cycle(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b0, 5'd4, 5'd6, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 18; i++) cycle(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b1);
    idle();

    // Reset while in WAIT aborts the wait without MemErr
    for (int i = 0; i < 2; i++) cycle(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < TO + 2; i++) cycle(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      cycle(($urandom_range(0, 59) == 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 1) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
